// File: rtl/alu_writeback.sv
// alu_writeback: result-consumer end of the execute-op interface.
// Accepted ALU results queue in an in-order FIFO and drain into a 16x32
// register file; APSR NZCV flags are updated at the push edge.
// Optional feature: define WB_BYPASS_EN to forward the youngest pending
// write to Rn/Rm (hazard flags then read 0).
module alu_writeback #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned NREG  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [3:0]  res_rd,
  input  logic [31:0] res_data,
  input  logic        res_wb,
  input  logic        res_S,
  input  logic        neg_in,
  input  logic        zero_in,
  input  logic        carry_in,
  input  logic        ovf_in,
  input  logic        wr_block,
  input  logic [3:0]  rn_idx,
  input  logic [3:0]  rm_idx,
  output logic [31:0] Rn,
  output logic [31:0] Rm,
  output logic        rn_hazard,
  output logic        rm_hazard,
  input  logic [3:0]  cond,
  output logic        cond_pass,
  output logic        neg_out,
  output logic        zero_out,
  output logic        carry_out,
  output logic        ovf_out,
  output logic        fifo_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic          q_wb   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   regs [NREG];
  logic          flag_n, flag_z, flag_c, flag_v;
  logic          full, empty, push, pop;
  logic          rn_hit, rm_hit;
`ifdef WB_BYPASS_EN
  logic [31:0]   rn_byp, rm_byp;
`endif

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign res_ready  = !full;
  assign fifo_empty = empty;
  assign push       = res_valid && !full;
  // Flags-only heads are discarded even while the write port is blocked.
  assign pop        = !empty && (!q_wb[rd_ptr] || !wr_block);

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
        q_wb[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        q_rd[wr_ptr]   <= res_rd;
        q_data[wr_ptr] <= res_data;
        q_wb[wr_ptr]   <= res_wb;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Register file write from the FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (pop && q_wb[rd_ptr]) begin
      regs[q_rd[rd_ptr]] <= q_data[rd_ptr];
    end
  end

  // APSR flags follow push order, independent of the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {flag_n, flag_z, flag_c, flag_v} <= '0;
    end else if (push && res_S) begin
      {flag_n, flag_z, flag_c, flag_v} <= {neg_in, zero_in, carry_in, ovf_in};
    end
  end

  assign neg_out   = flag_n;
  assign zero_out  = flag_z;
  assign carry_out = flag_c;
  assign ovf_out   = flag_v;

  // Condition code evaluation on the registered flags.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'd0:  cond_pass = flag_z;
      4'd1:  cond_pass = !flag_z;
      4'd2:  cond_pass = flag_c;
      4'd3:  cond_pass = !flag_c;
      4'd4:  cond_pass = flag_n;
      4'd5:  cond_pass = !flag_n;
      4'd6:  cond_pass = flag_v;
      4'd7:  cond_pass = !flag_v;
      4'd8:  cond_pass = flag_c && !flag_z;
      4'd9:  cond_pass = !flag_c || flag_z;
      4'd10: cond_pass = (flag_n == flag_v);
      4'd11: cond_pass = (flag_n != flag_v);
      4'd12: cond_pass = !flag_z && (flag_n == flag_v);
      4'd13: cond_pass = flag_z || (flag_n != flag_v);
      4'd14: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Scan pending entries oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [AW-1:0] slot;
    slot   = '0;
    rn_hit = 1'b0;
    rm_hit = 1'b0;
`ifdef WB_BYPASS_EN
    rn_byp = '0;
    rm_byp = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + AW'(k);
      if (((AW+1)'(k) < count) && q_wb[slot]) begin
        if (q_rd[slot] == rn_idx) begin
          rn_hit = 1'b1;
`ifdef WB_BYPASS_EN
          rn_byp = q_data[slot];
`endif
        end
        if (q_rd[slot] == rm_idx) begin
          rm_hit = 1'b1;
`ifdef WB_BYPASS_EN
          rm_byp = q_data[slot];
`endif
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign Rn        = rn_hit ? rn_byp : regs[rn_idx];
  assign Rm        = rm_hit ? rm_byp : regs[rm_idx];
  assign rn_hazard = 1'b0;
  assign rm_hazard = 1'b0;
`else
  assign Rn        = regs[rn_idx];
  assign Rm        = regs[rm_idx];
  assign rn_hazard = rn_hit;
  assign rm_hazard = rm_hit;
`endif

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Result-consumer end of the execute-op interface. Accepts Rd and NZCV results from the ALU ops (op_sub, op_add, ...) through a valid/ready handshake.
- Buffers accepted results in an in-order FIFO and drains them into a 16x32 register file.
- Owns the APSR NZCV flags and evaluates condition codes.
- Supplies Rn/Rm operands back to the execute ops, with hazard flags for registers that still have a write pending in the FIFO.

Parameters:
- DEPTH, 2, result FIFO entries (power of 2, ≥2)
- NREG, 16, architectural registers; index width fixed at 4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- res_valid  in  1  ALU result present
- res_ready  out  1  FIFO can accept
- res_rd  in  4  destination register index
- res_data  in  32  result value (Rd)
- res_wb  in  1  1 = write Rd; 0 = flags-only op (CMP-style)
- res_S  in  1  update flags
- neg_in, zero_in, carry_in, ovf_in  in  1 each  flags from the ALU op
- wr_block  in  1  register-file write port taken by another source this cycle
- rn_idx, rm_idx  in  4 each  operand read indices
- Rn, Rm  out  32 each  operand data
- rn_hazard, rm_hazard  out  1 each  pending write to that index exists
- cond  in  4  condition code
- cond_pass  out  1  condition satisfied
- neg_out, zero_out, carry_out, ovf_out  out  1 each  current APSR flags
- fifo_empty  out  1  no pending results

Behaviour:
- Reset (async, any time including mid-drain):
  - FIFO emptied; res_ready=1; fifo_empty=1.
  - All registers 0; all flags 0.
  - Rn=Rm=0 for any index; hazards 0.
- res_ready = !full, combinational from registered count only. It does not depend on same-cycle pop, so a full FIFO stalls for ≥1 cycle.
- Push on res_valid & res_ready at the clock edge. Entry = {rd, data, wb}.
- Flags are written at the push edge when res_S=1: N/Z/C/V <= neg_in/zero_in/carry_in/ovf_in. With res_S=0 the flags hold.
- Flag updates are independent of the FIFO drain. Program order is preserved because pushes are in order.
- Pop rule: when !empty, the head pops at the edge if head.wb=0 (discard), or if head.wb=1 and wr_block=0 (write regfile[rd] <= data).
- wr_block=1 with a wb=1 head leaves the FIFO unchanged.
- Push and pop in the same cycle are both performed; count is unchanged.
- Read ports are combinational from the register file. Index 15 is an ordinary register.
- Hazard:
  - rX_hazard = 1 if any valid FIFO entry has wb=1 and rd==rX_idx.
  - The same-cycle incoming push is not included.
- cond_pass is combinational from the registered flags, not the same-cycle update:
  - 0 EQ Z
  - 1 NE !Z
  - 2 CS C
  - 3 CC !C
  - 4 MI N
  - 5 PL !N
  - 6 VS V
  - 7 VC !V
  - 8 HI C&!Z
  - 9 LS !C|Z
  - 10 GE N==V
  - 11 LT N!=V
  - 12 GT !Z&(N==V)
  - 13 LE Z|(N!=V)
  - 14 AL 1
  - 15 0
- Latency: a result pushed at edge k with wr_block low is visible on Rn/Rm after edge k+1 when the FIFO was empty before the push.
- Flags are visible after edge k.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined:
  - Rn/Rm return the data of the youngest valid FIFO entry with wb=1 and matching rd, else the register file.
  - rn_hazard/rm_hazard are forced 0.
- When undefined: register-file-only reads with hazard flags as above.

Test Plan:
- Reset mid-drain: push {rd=3, data=0xDEADBEEF, wb=1} with wr_block=1, assert rst → fifo_empty=1, Rn(idx 3)=0, all flags 0, res_ready=1.
- Basic writeback: push {rd=5, data=0x12345678, wb=1, S=1, Z=0, C=1}, wr_block=0:
  - next cycle carry_out=1, rn_hazard(5)=1;
  - following cycle Rn(5)=0x12345678, rn_hazard=0.
- Backpressure: hold wr_block=1 and push 2 results → res_ready=0, third valid is not accepted. Drop wr_block → the FIFO drains one entry per cycle in order, and res_ready rises after the first pop.
- Flags-only op: push {rd=7, wb=0, S=1, N=1, V=0}, with regfile[7]=0xA:
  - regfile[7] stays 0xA;
  - entry discarded despite wr_block=1;
  - cond=11 (LT) → cond_pass=1.
- Condition sweep: force NZCV=0110 → cond 0,2,8,9 give pass 1,1,0,1; cond 14 → 1; cond 15 → 0.
- WB_BYPASS_EN: with wr_block=1, push rd=2 data=0x1 then rd=2 data=0x2 → Rn(2)=0x2 and rn_hazard=0 (undefined build: Rn(2)=0, rn_hazard=1).
